dbus_demux2: RTL and testbench

Routes one data-bus master (CPU load/store port) to one of two slaves (slave 0 = data RAM, slave 1 = memory-mapped IO). The slave is selected by a single address bit. The block registers the transaction and holds the request to the selected slave until that slave acknowledges. It then returns the read data and a one-cycle ack to the master. It is the steering and return-path counterpart of the 2-to-1 data mux in the datapath and sits between the MEM stage and the memory/IO slaves.

---
 rtl/dbus_demux2.sv | 151 +++++++++++++++
 tb/tb_dbus_demux2.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dbus_demux2.sv
// dbus_demux2 - steers one data-bus master to one of two slaves.
//
// Slave 0 is the data RAM and slave 1 is memory-mapped IO. Address bit
// SEL_BIT picks the slave. A request is latched in IDLE, and the selected
// slave's request is held in BUSY until that slave acks. DONE then returns
// a one-cycle ack, with read data, to the master.
//
// Optional feature: define DBUS_DEMUX_TIMEOUT_EN to enable a BUSY-cycle
// watchdog. After TIMEOUT BUSY cycles without an ack, the block completes
// with o_m_err=1 and o_m_rdat=32'hDEADBEEF.
//
// Ports:
//   i_clk, i_rst                 clock, async active-high reset
//   i_m_req/we/addr/wdat         master request side
//   o_m_ack/rdat/err             master completion side
//   o_s0_*, o_s1_*               per-slave req/we/addr/wdat
//   i_s0_ack/rdat, i_s1_ack/rdat per-slave acknowledge and read data
//
// state | meaning
// IDLE  | waiting for master request
// BUSY  | request held on selected slave until its ack
// DONE  | one-cycle ack to master
module dbus_demux2 #(
    parameter int SEL_BIT = 31,
    parameter int TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_m_req,
    input  logic        i_m_we,
    input  logic [31:0] i_m_addr,
    input  logic [31:0] i_m_wdat,
    output logic        o_m_ack,
    output logic [31:0] o_m_rdat,
    output logic        o_m_err,
    output logic        o_s0_req,
    output logic        o_s0_we,
    output logic [31:0] o_s0_addr,
    output logic [31:0] o_s0_wdat,
    input  logic        i_s0_ack,
    input  logic [31:0] i_s0_rdat,
    output logic        o_s1_req,
    output logic        o_s1_we,
    output logic [31:0] o_s1_addr,
    output logic [31:0] o_s1_wdat,
    input  logic        i_s1_ack,
    input  logic [31:0] i_s1_rdat
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic        r_sel;
    logic [31:0] r_addr;
    logic [31:0] r_wdat;
    logic [31:0] r_rdat;
    logic        w_busy;
    logic        w_sel_ack;
    logic [31:0] w_sel_rdat;
    logic        w_timeout;

    assign w_busy     = (r_state == BUSY);
    // Only the selected slave's ack counts; the other slave is ignored.
    assign w_sel_ack  = r_sel ? i_s1_ack : i_s0_ack;
    assign w_sel_rdat = r_sel ? i_s1_rdat : i_s0_rdat;

`ifdef DBUS_DEMUX_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] r_cnt;
    logic       r_err;

    // r_cnt counts completed BUSY cycles, so this fires in the TIMEOUT-th one.
    assign w_timeout = w_busy && (r_cnt == TO_LAST);
    assign o_m_err   = r_err;
`else
    assign w_timeout = 1'b0;
    assign o_m_err   = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (i_m_req) w_next = BUSY;
            BUSY: if (w_sel_ack || w_timeout) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_we   <= 1'b0;
            r_sel  <= 1'b0;
            r_addr <= '0;
            r_wdat <= '0;
            r_rdat <= '0;
        end else begin
            if (r_state == IDLE && i_m_req) begin
                r_we   <= i_m_we;
                r_sel  <= i_m_addr[SEL_BIT];
                r_addr <= i_m_addr;
                r_wdat <= i_m_wdat;
            end
            // Ack wins over a coincident timeout; writes leave rdat untouched.
            if (w_busy && w_sel_ack) begin
                if (!r_we) r_rdat <= w_sel_rdat;
            end else if (w_timeout) begin
                r_rdat <= 32'hDEAD_BEEF;
            end
        end
    end

`ifdef DBUS_DEMUX_TIMEOUT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == IDLE && i_m_req) r_cnt <= '0;
            else if (w_busy)                r_cnt <= r_cnt + 8'd1;
            r_err <= w_busy && !w_sel_ack && w_timeout;
        end
    end
`endif

    assign o_m_ack   = (r_state == DONE);
    assign o_m_rdat  = r_rdat;
    assign o_s0_req  = w_busy && !r_sel;
    assign o_s1_req  = w_busy && r_sel;
    assign o_s0_we   = r_we && o_s0_req;
    assign o_s1_we   = r_we && o_s1_req;
    assign o_s0_addr = r_addr;
    assign o_s1_addr = r_addr;
    assign o_s0_wdat = r_wdat;
    assign o_s1_wdat = r_wdat;

endmodule

// File: tb/tb_dbus_demux2.sv
module tb_dbus_demux2;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdat;
    logic        m_ack, m_err;
    logic [31:0] m_rdat;
    logic        s0_req, s0_we, s1_req, s1_we;
    logic [31:0] s0_addr, s0_wdat, s1_addr, s1_wdat;
    logic        s0_ack, s1_ack;
    logic [31:0] s0_rdat, s1_rdat;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_ack = 0;
    logic        prev_ack = 1'b0;
    logic [32:0] exp_q[$];      // {err, rdat}
    logic [31:0] model_rdat = '0;

    always #5 clk = ~clk;

    dbus_demux2 #(
        .SEL_BIT(31)
`ifdef DBUS_DEMUX_TIMEOUT_EN
        , .TIMEOUT(4)
`endif
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_m_req(m_req), .i_m_we(m_we), .i_m_addr(m_addr), .i_m_wdat(m_wdat),
        .o_m_ack(m_ack), .o_m_rdat(m_rdat), .o_m_err(m_err),
        .o_s0_req(s0_req), .o_s0_we(s0_we), .o_s0_addr(s0_addr), .o_s0_wdat(s0_wdat),
        .i_s0_ack(s0_ack), .i_s0_rdat(s0_rdat),
        .o_s1_req(s1_req), .o_s1_we(s1_we), .o_s1_addr(s1_addr), .o_s1_wdat(s1_wdat),
        .i_s1_ack(s1_ack), .i_s1_rdat(s1_rdat)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Completion monitor: pops the scoreboard on every master ack.
    always @(negedge clk) begin
        logic [32:0] e;
        check("dual_req", {31'd0, s0_req & s1_req}, 32'd0);
        if (m_ack === 1'b1) begin
            n_ack++;
            check("ack_width", {31'd0, prev_ack}, 32'd0);
            if (exp_q.size() == 0) begin
                check("spurious_ack", {31'd0, m_ack}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rdat", m_rdat, e[31:0]);
                check("err", {31'd0, m_err}, {31'd0, e[32]});
            end
        end
        prev_ack = m_ack;
    end

    task automatic push_exp(input logic err, input logic [31:0] rdat);
        exp_q.push_back({err, rdat});
        model_rdat = rdat;
    endtask

    // One transaction; dly = slave req cycles before ack, wrong = other slave acks first.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdat,
                       input int dly, input logic [31:0] srdat, input logic wrong);
        logic sel;
        int   a0;
        sel = addr[31];
        a0  = n_ack;
        m_req = 1'b1; m_we = we; m_addr = addr; m_wdat = wdat;
        push_exp(1'b0, we ? model_rdat : srdat);
        @(negedge clk);
        m_req = 1'b0;
        check("s0_req", {31'd0, s0_req}, {31'd0, !sel});
        check("s1_req", {31'd0, s1_req}, {31'd0, sel});
        check("sel_we", {31'd0, sel ? s1_we : s0_we}, {31'd0, we});
        check("oth_we", {31'd0, sel ? s0_we : s1_we}, 32'd0);
        check("sel_addr", sel ? s1_addr : s0_addr, addr);
        check("sel_wdat", sel ? s1_wdat : s0_wdat, wdat);
        for (int i = 0; i < dly; i++) begin
            if (wrong && i < 2) begin
                if (sel) begin s0_ack = 1'b1; s0_rdat = 32'hBAD0_BAD0; end
                else     begin s1_ack = 1'b1; s1_rdat = 32'hBAD0_BAD0; end
            end
            @(negedge clk);
            s0_ack = 1'b0; s1_ack = 1'b0;
            check("early_ack", {31'd0, m_ack}, 32'd0);
            check("oth_req", {31'd0, sel ? s0_req : s1_req}, 32'd0);
        end
        if (sel) begin s1_ack = 1'b1; s1_rdat = srdat; end
        else     begin s0_ack = 1'b1; s0_rdat = srdat; end
        @(negedge clk);
        s0_ack = 1'b0; s1_ack = 1'b0; s0_rdat = '0; s1_rdat = '0;
        check("done_req", {31'd0, s0_req | s1_req}, 32'd0);
        @(negedge clk);
        check("ack_count", n_ack - a0, 32'd1);
        check("idle_ack", {31'd0, m_ack}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdat = '0;
        s0_ack = 1'b0; s1_ack = 1'b0; s0_rdat = '0; s1_rdat = '0;
        repeat (2) @(negedge clk);
        check("rst_ack", {31'd0, m_ack}, 32'd0);
        check("rst_rdat", m_rdat, 32'd0);
        check("rst_err", {31'd0, m_err}, 32'd0);
        check("rst_req", {30'd0, s0_req, s1_req}, 32'd0);
        check("rst_addr", s0_addr, 32'd0);
        check("rst_wdat", s1_wdat, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Slave acks while idle must not produce a master ack.
        s0_ack = 1'b1; s1_ack = 1'b1;
        @(negedge clk);
        s0_ack = 1'b0; s1_ack = 1'b0;
        @(negedge clk);
        check("idle_slave_ack", {31'd0, m_ack}, 32'd0);

        txn(1'b0, 32'h0000_0010, 32'h0, 3, 32'h1234_5678, 1'b0);
        txn(1'b1, 32'h8000_0004, 32'hCAFE_F00D, 1, 32'h5555_AAAA, 1'b0);
        txn(1'b0, 32'h0000_0100, 32'h0, 3, 32'hA5A5_0001, 1'b1);
        txn(1'b0, 32'h8000_0200, 32'h0, 0, 32'h0BAD_F00D, 1'b0);
        txn(1'b1, 32'h0000_0300, 32'h1357_9BDF, 0, 32'h7777_7777, 1'b1);

        // Back-to-back reads with req held high across both.
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0020;
        push_exp(1'b0, 32'h1111_1111);
        @(negedge clk);
        check("b2b_s0_req", {31'd0, s0_req}, 32'd1);
        s0_ack = 1'b1; s0_rdat = 32'h1111_1111;
        m_addr = 32'h8000_0020;
        push_exp(1'b0, 32'h2222_2222);
        @(negedge clk);
        s0_ack = 1'b0;
        check("b2b_ack1", {31'd0, m_ack}, 32'd1);
        @(negedge clk);
        check("b2b_idle", {30'd0, s0_req, s1_req}, 32'd0);
        check("b2b_idle_ack", {31'd0, m_ack}, 32'd0);
        @(negedge clk);
        check("b2b_s1_req", {31'd0, s1_req}, 32'd1);
        check("b2b_s1_addr", s1_addr, 32'h8000_0020);
        s1_ack = 1'b1; s1_rdat = 32'h2222_2222;
        @(negedge clk);
        s1_ack = 1'b0; m_req = 1'b0;
        check("b2b_ack2", {31'd0, m_ack}, 32'd1);
        @(negedge clk);

        // Reset between edges during BUSY.
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0040;
        @(negedge clk);
        m_req = 1'b0;
        check("pre_rst_req", {31'd0, s0_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_req_drop", {31'd0, s0_req}, 32'd0);
        check("async_rdat", m_rdat, 32'd0);
        model_rdat = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ack", {31'd0, m_ack}, 32'd0);
        txn(1'b0, 32'h0000_0044, 32'h0, 1, 32'h4444_4444, 1'b0);

`ifdef DBUS_DEMUX_TIMEOUT_EN
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0050;
        push_exp(1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        m_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("to_req", {31'd0, s0_req}, 32'd1);
            @(negedge clk);
        end
        check("to_req4", {31'd0, s0_req}, 32'd1);
        @(negedge clk);
        check("to_ack", {31'd0, m_ack}, 32'd1);
        check("to_req_drop", {31'd0, s0_req}, 32'd0);
        @(negedge clk);
        check("to_err_clr", {31'd0, m_err}, 32'd0);
`endif

        repeat (2) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
